// File: rtl/risc16_pkg.sv
// Shared constants and word type for the 16-bit RISC datapath.
package risc16_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef logic [DATA_W-1:0] word_t;

endpackage : risc16_pkg

// File: rtl/risc16_data_mem.sv
// Word-addressed data memory for the MEM stage: synchronous write,
// combinational gated read, asynchronous clear of the whole array.
module risc16_data_mem #(
  parameter int unsigned DATA_W     = risc16_pkg::DATA_W,
  parameter int unsigned ADDR_W     = risc16_pkg::ADDR_W,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;

  // Upper address bits alias modulo the depth.
  assign idx = addr[DEPTH_LOG2-1:0];

  if (DEPTH_LOG2 < ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2];
  end

  // Reset wipes every word; writes are blocked while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[DEPTH_LOG2'(i)] <= '0;
      end
    end else if (mem_wr) begin
      mem[idx] <= write_data;
    end
  end

  // No write_data bypass: a same-address write shows only after the edge.
  assign read_data = mem_rd ? mem[idx] : '0;

endmodule : risc16_data_mem

// File: tb/tb_risc16_data_mem.sv
// Scoreboard bench for risc16_data_mem: stimulus queues expected words,
// a monitor compares read_data whenever the stimulus presents a sample point.
module tb_risc16_data_mem;
  import risc16_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] addr;
  word_t       write_data;
  word_t       read_data;

  typedef struct {
    string name;
    word_t exp;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   n_vec;
  int   n_fail;

  risc16_data_mem #(.DEPTH_LOG2(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each sample point pops one expectation and compares.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL sample_without_expectation: read_data=%h required=none", read_data);
      end else begin
        e = sb_q.pop_front();
        n_vec++;
        if (read_data !== e.exp) begin
          n_fail++;
          $display("FAIL %s: read_data=%h required=%h (t=%0t)", e.name, read_data, e.exp, $time);
        end
      end
    end
  end

  // Settle combinational read path, then present a sample point.
  task automatic expect_rd(input string name, input word_t exp);
    exp_t e;
    #1;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  // Move to just after the next rising edge.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] a, input word_t d);
    mem_rd     = 1'b0;
    mem_wr     = 1'b1;
    addr       = a;
    write_data = d;
    edge1();
    mem_wr     = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [15:0] a, input word_t exp);
    mem_rd = 1'b1;
    addr   = a;
    expect_rd(name, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time=%0t required=<100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    mem_rd     = 1'b1;
    mem_wr     = 1'b0;
    addr       = 16'h0000;
    write_data = 16'h0000;
    #2;
    read_chk("reset_word0", 16'h0000, 16'h0000);
    read_chk("reset_word_ff", 16'h00FF, 16'h0000);
    edge1();
    rst = 1'b0;

    // Store then load
    write_word(16'h0004, 16'h1234);
    read_chk("store_load_0004", 16'h0004, 16'h1234);

    // Read gating without any clock edge
    mem_rd = 1'b0;
    expect_rd("gate_rd0", 16'h0000);
    mem_rd = 1'b1;
    expect_rd("gate_rd1", 16'h1234);

    // Aliasing modulo 256 words
    write_word(16'h0105, 16'hA5A5);
    read_chk("alias_0005", 16'h0005, 16'hA5A5);
    read_chk("alias_0105", 16'h0105, 16'hA5A5);
    read_chk("alias_ff05", 16'hFF05, 16'hA5A5);
    read_chk("alias_keeps_0004", 16'h0004, 16'h1234);

    // Index boundaries
    write_word(16'h00FF, 16'hCAFE);
    write_word(16'h0000, 16'h0F0F);
    read_chk("top_word_00ff", 16'h00FF, 16'hCAFE);
    read_chk("bottom_word_0000", 16'h0000, 16'h0F0F);
    read_chk("alias_0100", 16'h0100, 16'h0F0F);

    // Simultaneous read/write: old word before edge, new word after
    write_word(16'h0020, 16'h1111);
    mem_rd     = 1'b1;
    mem_wr     = 1'b1;
    addr       = 16'h0020;
    write_data = 16'h2222;
    expect_rd("rdwr_before_edge", 16'h1111);
    edge1();
    expect_rd("rdwr_after_edge", 16'h2222);
    mem_wr = 1'b0;

    // No-write hold while write_data and addr wander
    for (int i = 0; i < 5; i++) begin
      write_data = 16'h5A5A ^ 16'(i * 16'h1111);
      addr       = 16'(16'h0004 + i);
      edge1();
    end
    read_chk("hold_0004", 16'h0004, 16'h1234);
    read_chk("hold_0005", 16'h0005, 16'hA5A5);
    read_chk("hold_0020", 16'h0020, 16'h2222);
    read_chk("hold_00ff", 16'h00FF, 16'hCAFE);

    // Reset pulse between clock edges clears immediately
    write_word(16'h0010, 16'hBEEF);
    read_chk("pre_reset_0010", 16'h0010, 16'hBEEF);
    rst = 1'b1;
    expect_rd("in_reset_0010", 16'h0000);
    rst = 1'b0;
    read_chk("post_reset_0010", 16'h0010, 16'h0000);
    read_chk("post_reset_0004", 16'h0004, 16'h0000);

    // Write with reset held at an edge is blocked
    rst        = 1'b1;
    mem_wr     = 1'b1;
    addr       = 16'h0010;
    write_data = 16'hDEAD;
    edge1();
    read_chk("wr_blocked_in_reset", 16'h0010, 16'h0000);
    mem_wr = 1'b0;
    rst    = 1'b0;
    read_chk("wr_blocked_after_reset", 16'h0010, 16'h0000);

    // First edge with reset low takes the write
    mem_wr = 1'b1;
    expect_rd("first_wr_before_edge", 16'h0000);
    edge1();
    mem_wr = 1'b0;
    read_chk("first_wr_after_reset", 16'h0010, 16'hDEAD);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_risc16_data_mem

// File: doc/risc16_data_mem.md
Name: risc16_data_mem

Overview:
- Word-addressed data memory for the 16-bit RISC processor, serving LOAD/STORE from the MEM stage.
- Writes are synchronous on the rising clock edge; reads are combinational and gated by the read enable.
- Asynchronous reset clears the whole array, so simulation and hardware start from a known all-zero state.

Parameters:
- DATA_W, 16, width of each memory word and of write_data/read_data.
- ADDR_W, 16, width of the addr port.
- DEPTH_LOG2, 8, log2 of the number of words (default 256 words); must be <= ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge except reset.
- rst  input  1  reset, asynchronous, active-high.
- mem_rd  input  1  read enable.
- mem_wr  input  1  write enable.
- addr  input  ADDR_W  word address, not byte address.
- write_data  input  DATA_W  store data.
- read_data  output  DATA_W  load data.

Behaviour:
- Storage: 2**DEPTH_LOG2 words of DATA_W bits.
- Index: addr[DEPTH_LOG2-1:0]; upper address bits are ignored, so addresses alias modulo the depth.
- Reset:
  - rst=1 clears every word to 0 immediately, independent of clk.
  - Writes are blocked while rst=1.
  - read_data reads 0 during reset because the array is 0.
  - Deasserting rst mid-operation: the first write takes effect at the first rising edge with rst=0.
- Write:
  - At a rising clk edge with rst=0 and mem_wr=1, mem[index] <= write_data.
  - The written value is visible on read_data in the same cycle after the edge.
  - mem_wr=0 leaves the array unchanged.
- Read:
  - Combinational, zero-cycle latency.
  - read_data = mem[index] when mem_rd=1.
  - read_data = 0 when mem_rd=0.
  - read_data follows addr and mem changes within the same delta.
- mem_rd and mem_wr both 1 on the same address:
  - Before the edge, read_data shows the old word.
  - After the edge, it shows the new word (no bypass of write_data).
- No handshake, no busy/ready; every access completes in one cycle.
- X/undefined addr bits: no requirement beyond simulation propagation.

Decomposition:
- Shared package risc16_pkg holds DATA_W=16 and ADDR_W=16 constants, plus a word_t typedef (logic [15:0]) reused by the register file and the ALU.
- Depth stays a module parameter, not a package constant.
- No sub-module; the array, write process and read mux live in one module.

Test Plan:
- Store/load: edge with addr=0x0004, write_data=0x1234, mem_wr=1; then mem_wr=0, mem_rd=1, addr=0x0004 -> read_data=0x1234 combinationally.
- Read gating: mem_rd=0, addr=0x0004 after the above -> read_data=0x0000; raise mem_rd -> 0x1234 with no clock edge.
- Reset:
  - Write 0xBEEF to 0x0010.
  - Pulse rst between clock edges -> read of 0x0010 (mem_rd=1) returns 0x0000 immediately.
  - Write attempted with rst=1 at an edge -> word stays 0.
- Aliasing (DEPTH_LOG2=8): write 0xA5A5 to 0x0105 -> read at 0x0005 returns 0xA5A5.
- Simultaneous rd/wr:
  - addr=0x0020 holds 0x1111; mem_rd=1, mem_wr=1, write_data=0x2222.
  - read_data=0x1111 before the edge and 0x2222 after it.
- No-write hold: mem_wr=0 with write_data toggling over 5 edges -> all previously written words unchanged; read back 0x0004=0x1234.
